// File: rtl/pipe_ctrl_unit.sv
// pipe_ctrl_unit: decodes the ID-stage opcode into pipeline control bits,
// carries them through ID/EX, EX/MEM and MEM/WB, detects load-use stalls,
// applies flushes, and halts the front end once an ECALL has drained.
module pipe_ctrl_unit #(
  parameter bit ENABLE_JUMP = 1'b1,
  parameter int REG_IDX_W   = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 id_valid,
  input  logic [6:0]           id_opcode,
  input  logic [REG_IDX_W-1:0] id_rs1,
  input  logic [REG_IDX_W-1:0] id_rs2,
  input  logic [REG_IDX_W-1:0] id_rd,
  input  logic                 flush,
  output logic                 pc_write,
  output logic                 if_id_write,
  output logic                 ex_alu_src,
  output logic                 ex_is_jal,
  output logic                 ex_is_jalr,
  output logic [1:0]           ex_alu_op,
  output logic [REG_IDX_W-1:0] ex_rd,
  output logic                 mem_mem_read,
  output logic                 mem_mem_write,
  output logic [REG_IDX_W-1:0] mem_rd,
  output logic                 mem_reg_write,
  output logic                 wb_reg_write,
  output logic                 wb_mem_to_reg,
  output logic                 wb_pc_to_reg,
  output logic [REG_IDX_W-1:0] wb_rd,
  output logic                 halted
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_ARITH  = 7'b0110011;
  localparam logic [6:0] OP_ARITHI = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_ECALL  = 7'b1110011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_HALT} state_t;

  // Everything a decoded instruction carries into EX.
  typedef struct packed {
    logic                 alu_src;
    logic                 is_jal;
    logic                 is_jalr;
    logic [1:0]           alu_op;
    logic                 mem_read;
    logic                 mem_write;
    logic                 reg_write;
    logic                 mem_to_reg;
    logic                 pc_to_reg;
    logic                 is_ecall;
    logic [REG_IDX_W-1:0] rd;
  } idex_t;

  // EX/MEM keeps only what MEM, WB and the halt detection still need.
  typedef struct packed {
    logic                 mem_read;
    logic                 mem_write;
    logic                 reg_write;
    logic                 mem_to_reg;
    logic                 pc_to_reg;
    logic                 is_ecall;
    logic [REG_IDX_W-1:0] rd;
  } exmem_t;

  typedef struct packed {
    logic                 reg_write;
    logic                 mem_to_reg;
    logic                 pc_to_reg;
    logic [REG_IDX_W-1:0] rd;
  } memwb_t;

  state_t state_q;
  logic   halted_q;
  idex_t  dec, idex_d, idex_q;
  exmem_t exmem_d, exmem_q;
  memwb_t memwb_d, memwb_q;
  logic   uses_rs1, uses_rs2, hazard, running, issue;

  // Opcode decode; anything unknown or invalid is a bubble with rd=0.
  always_comb begin
    dec      = '0;
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    if (id_valid) begin
      case (id_opcode)
        OP_LOAD: begin
          dec.mem_read = 1'b1; dec.mem_to_reg = 1'b1; dec.alu_src = 1'b1;
          dec.reg_write = 1'b1; dec.rd = id_rd; uses_rs1 = 1'b1;
        end
        OP_STORE: begin
          dec.mem_write = 1'b1; dec.alu_src = 1'b1; dec.rd = id_rd;
          uses_rs1 = 1'b1; uses_rs2 = 1'b1;
        end
        OP_ARITH: begin
          dec.reg_write = 1'b1; dec.alu_op = 2'b10; dec.rd = id_rd;
          uses_rs1 = 1'b1; uses_rs2 = 1'b1;
        end
        OP_ARITHI: begin
          dec.alu_src = 1'b1; dec.reg_write = 1'b1; dec.alu_op = 2'b10;
          dec.rd = id_rd; uses_rs1 = 1'b1;
        end
        OP_BRANCH: begin
          dec.alu_op = 2'b01; dec.rd = id_rd; uses_rs1 = 1'b1; uses_rs2 = 1'b1;
        end
        // ECALL never writes a register, so rd stays 0.
        OP_ECALL: dec.is_ecall = 1'b1;
        OP_JAL: if (ENABLE_JUMP) begin
          dec.reg_write = 1'b1; dec.pc_to_reg = 1'b1; dec.is_jal = 1'b1;
          dec.rd = id_rd;
        end
        OP_JALR: if (ENABLE_JUMP) begin
          dec.alu_src = 1'b1; dec.reg_write = 1'b1; dec.pc_to_reg = 1'b1;
          dec.is_jalr = 1'b1; dec.rd = id_rd; uses_rs1 = 1'b1;
        end
        default: dec = '0;
      endcase
    end
  end

  // Load-use stall and front-end gating; flush overrides a stall.
  always_comb begin
    hazard = idex_q.mem_read && (idex_q.rd != '0) &&
             (((idex_q.rd == id_rs1) && uses_rs1) ||
              ((idex_q.rd == id_rs2) && uses_rs2));
    running     = (state_q == ST_RUN);
    pc_write    = running && (flush || !hazard);
    if_id_write = pc_write;
    issue       = running && !flush && !hazard;
  end

  // Next values for the three stage registers.
  always_comb begin
    idex_d             = issue ? dec : '0;
    exmem_d.mem_read   = idex_q.mem_read;
    exmem_d.mem_write  = idex_q.mem_write;
    exmem_d.reg_write  = idex_q.reg_write;
    exmem_d.mem_to_reg = idex_q.mem_to_reg;
    exmem_d.pc_to_reg  = idex_q.pc_to_reg;
    exmem_d.is_ecall   = idex_q.is_ecall;
    exmem_d.rd         = idex_q.rd;
    memwb_d.reg_write  = exmem_q.reg_write;
    memwb_d.mem_to_reg = exmem_q.mem_to_reg;
    memwb_d.pc_to_reg  = exmem_q.pc_to_reg;
    memwb_d.rd         = exmem_q.rd;
  end

  // Stage registers; downstream stages always advance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idex_q  <= '0;
      exmem_q <= '0;
      memwb_q <= '0;
    end else begin
      idex_q  <= idex_d;
      exmem_q <= exmem_d;
      memwb_q <= memwb_d;
    end
  end

  // Run/drain/halt control; halt is taken as the ECALL moves into MEM/WB.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_RUN;
      halted_q <= 1'b0;
    end else begin
      case (state_q)
        ST_RUN:   if (issue && dec.is_ecall) state_q <= ST_DRAIN;
        ST_DRAIN: if (exmem_q.is_ecall) begin
          state_q  <= ST_HALT;
          halted_q <= 1'b1;
        end
        ST_HALT:  state_q <= ST_HALT;
        default:  state_q <= ST_RUN;
      endcase
    end
  end

  assign ex_alu_src    = idex_q.alu_src;
  assign ex_is_jal     = idex_q.is_jal;
  assign ex_is_jalr    = idex_q.is_jalr;
  assign ex_alu_op     = idex_q.alu_op;
  assign ex_rd         = idex_q.rd;
  assign mem_mem_read  = exmem_q.mem_read;
  assign mem_mem_write = exmem_q.mem_write;
  assign mem_rd        = exmem_q.rd;
  assign mem_reg_write = exmem_q.reg_write;
  assign wb_reg_write  = memwb_q.reg_write;
  assign wb_mem_to_reg = memwb_q.mem_to_reg;
  assign wb_pc_to_reg  = memwb_q.pc_to_reg;
  assign wb_rd         = memwb_q.rd;
  assign halted        = halted_q;

endmodule
